// File: rtl/moving_average_ctrl.sv
// moving_average_ctrl: scrub / clear / run sequencer wrapped around the moving_average datapath.
// Build option: define MA_CTRL_TRIG_EN to add the thresh input and the trig output with holdoff.

module moving_average_ctrl #(
  parameter int DIN_WIDTH  = 32,
  parameter int WINDOW_LEN = 16,
  parameter int MA_LATENCY = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int HOLDOFF    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 en,
  input  logic                 restart,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic [DIN_WIDTH-1:0] ma_din,
  output logic                 ma_din_valid,
  output logic                 ma_rst,
  input  logic [DIN_WIDTH-1:0] ma_dout,
  input  logic                 ma_dout_valid,
  output logic [DIN_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 settled,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] drop_cnt
`ifdef MA_CTRL_TRIG_EN
  ,
  input  logic [DIN_WIDTH-1:0] thresh,
  output logic                 trig
`endif
);

  // state | meaning
  // IDLE  | datapath held in reset, waiting for en
  // ZERO  | writing WINDOW_LEN zero samples into the delay line
  // DRAIN | letting the scrub samples flush out of the datapath pipeline
  // CLR   | one-cycle datapath reset to clear integrator and addresses
  // RUN   | registered pass-through of upstream samples
  typedef enum logic [2:0] {IDLE, ZERO, DRAIN, CLR, RUN} state_t;

  localparam int TMR_W  = $clog2(WINDOW_LEN + MA_LATENCY + 1);
  localparam int VCNT_W = $clog2(WINDOW_LEN);
  localparam logic [TMR_W-1:0]  ZERO_TC  = TMR_W'(WINDOW_LEN - 1);
  localparam logic [TMR_W-1:0]  DRAIN_TC = TMR_W'(MA_LATENCY);
  localparam logic [VCNT_W-1:0] VCNT_LAST = VCNT_W'(WINDOW_LEN - 1);

  state_t               state, state_n;
  logic [TMR_W-1:0]     tmr, tmr_n;
  logic [DIN_WIDTH-1:0] din_q;
  logic                 din_valid_q;
  logic [VCNT_W-1:0]    vcnt;
  logic                 settled_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
    end else if (ce) begin
      state <= state_n;
      tmr   <= tmr_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    case (state)
      IDLE: begin
        if (en) begin
          state_n = ZERO;
          tmr_n   = ZERO_TC;
        end
      end
      ZERO: begin
        if (tmr == '0) begin
          state_n = DRAIN;
          tmr_n   = DRAIN_TC;
        end else begin
          tmr_n = tmr - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (tmr == '0) state_n = CLR;
        else           tmr_n = tmr - TMR_W'(1);
      end
      CLR:     state_n = RUN;
      RUN:     state_n = RUN;
      default: state_n = IDLE;
    endcase
    // en drop wins over restart; restart is meaningless while parked in IDLE
    if (state != IDLE) begin
      if (!en) begin
        state_n = IDLE;
        tmr_n   = '0;
      end else if (restart) begin
        state_n = ZERO;
        tmr_n   = ZERO_TC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q       <= '0;
      din_valid_q <= 1'b0;
      drop_cnt    <= '0;
    end else if (ce) begin
      din_q       <= (state == RUN) ? din : '0;
      din_valid_q <= (state == RUN) && din_valid;
      if (din_valid && state != RUN && drop_cnt != {CNT_WIDTH{1'b1}})
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign ma_din       = (state == RUN) ? din_q : '0;
  assign ma_din_valid = (state == ZERO) || ((state == RUN) && din_valid_q);
  assign ma_rst       = (state == IDLE) || (state == CLR);
  assign busy         = (state == ZERO) || (state == DRAIN) || (state == CLR);
  assign dout         = ma_dout;
  assign dout_valid   = ma_dout_valid && (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt      <= '0;
      settled_q <= 1'b0;
    end else if (ce) begin
      if (state_n != RUN) begin
        vcnt      <= '0;
        settled_q <= 1'b0;
      end else if (dout_valid && !settled_q) begin
        if (vcnt == VCNT_LAST) settled_q <= 1'b1;
        else                   vcnt <= vcnt + VCNT_W'(1);
      end
    end
  end

  // the output carrying the WINDOW_LEN-th post-clear sample is already a full window
  assign settled = settled_q || (dout_valid && vcnt == VCNT_LAST);

`ifdef MA_CTRL_TRIG_EN
  localparam int HO_W = $clog2(HOLDOFF + 1);
  logic [HO_W-1:0] holdoff;
  logic            trig_cond;

  assign trig_cond = dout_valid && settled && ($signed(dout) > $signed(thresh)) && (holdoff == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      trig    <= 1'b0;
      holdoff <= '0;
    end else if (ce) begin
      if (state_n != RUN) begin
        trig    <= 1'b0;
        holdoff <= '0;
      end else begin
        trig <= trig_cond;
        if (trig_cond)          holdoff <= HO_W'(HOLDOFF - 1);
        else if (holdoff != '0) holdoff <= holdoff - HO_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_moving_average_ctrl.sv
// Bench for moving_average_ctrl: behavioural datapath stand-in plus window-sum reference model.
// Define MA_CTRL_TRIG_EN to also exercise the threshold trigger.

module tb_moving_average_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic [31:0] ma_din;
  logic        ma_din_valid;
  logic        ma_rst;
  logic [31:0] ma_dout;
  logic        ma_dout_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        settled;
  logic        busy;
  logic [15:0] drop_cnt;
`ifdef MA_CTRL_TRIG_EN
  logic [31:0] thresh = 32'd10;
  logic        trig;
`endif

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  always #5 clk = ~clk;

  moving_average_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce), .en(en), .restart(restart),
    .din(din), .din_valid(din_valid),
    .ma_din(ma_din), .ma_din_valid(ma_din_valid), .ma_rst(ma_rst),
    .ma_dout(ma_dout), .ma_dout_valid(ma_dout_valid),
    .dout(dout), .dout_valid(dout_valid), .settled(settled), .busy(busy),
    .drop_cnt(drop_cnt)
`ifdef MA_CTRL_TRIG_EN
    , .thresh(thresh), .trig(trig)
`endif
  );

  // Stand-in datapath: 16-deep delay line, running integrator, 4-cycle output pipe.
  logic [31:0] mem [0:15];
  logic [3:0]  wp;
  logic [31:0] acc;
  logic [31:0] acc_n;
  logic [3:0]  pv;
  logic [31:0] pd [0:3];

  assign acc_n = acc + ma_din - mem[wp];
  assign ma_dout_valid = pv[3];
  assign ma_dout = pd[3];

  always @(posedge clk) begin
    if (ce) begin
      if (ma_rst) begin
        wp  <= '0;
        acc <= '0;
        pv  <= '0;
      end else begin
        if (ma_din_valid) begin
          mem[wp] <= ma_din;
          wp      <= wp + 4'd1;
          acc     <= acc_n;
        end
        pv    <= {pv[2:0], ma_din_valid};
        pd[0] <= acc_n;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
      end
    end
  end

  // Expected {ma_rst, ma_din_valid, busy} p cycles after en rose (no RUN traffic).
  function automatic logic [2:0] exp_phase(input int p);
    if (p == 0)       return 3'b100;
    else if (p <= 16) return 3'b011;
    else if (p <= 21) return 3'b001;
    else if (p == 22) return 3'b101;
    else              return 3'b000;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ma_rst, ma_din_valid, busy, settled, dout_valid} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got rst/dv/busy/settled/ov=%b required 10000",
               {ma_rst, ma_din_valid, busy, settled, dout_valid});
    end
    checks++;
    if (ma_din !== 32'd0 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: got ma_din=%0h drop_cnt=%0d required 0 0", ma_din, drop_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_scrub();
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      checks++;
      if ({ma_rst, ma_din_valid, busy} !== exp_phase(k) || ma_din !== 32'd0) begin
        errors++;
        $display("FAIL scrub_seq cycle %0d: got rst/dv/busy=%b din=%0h required %b 0",
                 k, {ma_rst, ma_din_valid, busy}, ma_din, exp_phase(k));
      end
      if (k >= 23) begin
        checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
          errors++;
          $display("FAIL scrub_drop: got %0d required %0d", drop_cnt, exp_drop);
        end
      end
      en = 1'b1;
      din_valid = (k >= 1 && k <= 22);
      if (din_valid) exp_drop++;
    end
  endtask

  // Starts on the first RUN cycle of a freshly cleared window.
  task automatic test_stream(input int mode, input int n);
    bit          exp_v [0:255];
    logic [31:0] exp_d [0:255];
    int          q[$];
    int          nvalid = 0;
    int          s;
    int          d;
    bit          v;
    bit          exp_settled;
`ifdef MA_CTRL_TRIG_EN
    bit          exp_trig = 1'b0;
    bit          cond;
    int          last_fire = -1000;
`endif
    for (int i = 0; i < 256; i++) exp_v[i] = 1'b0;
    for (int i = 0; i <= n + 5; i++) begin
      @(negedge clk);
      if (exp_v[i]) nvalid++;
      exp_settled = (nvalid >= 16);
      checks++;
      if (dout_valid !== exp_v[i]) begin
        errors++;
        $display("FAIL stream%0d_valid cycle %0d: got %b required %b", mode, i, dout_valid, exp_v[i]);
      end
      if (exp_v[i]) begin
        checks++;
        if (dout !== exp_d[i]) begin
          errors++;
          $display("FAIL stream%0d_data cycle %0d: got %0d required %0d",
                   mode, i, $signed(dout), $signed(exp_d[i]));
        end
      end
      checks++;
      if (settled !== exp_settled) begin
        errors++;
        $display("FAIL stream%0d_settled cycle %0d: got %b required %b", mode, i, settled, exp_settled);
      end
`ifdef MA_CTRL_TRIG_EN
      checks++;
      if (trig !== exp_trig) begin
        errors++;
        $display("FAIL stream%0d_trig cycle %0d: got %b required %b", mode, i, trig, exp_trig);
      end
      cond = exp_v[i] && exp_settled && ($signed(exp_d[i]) > $signed(thresh)) && (i - last_fire >= 64);
      if (cond) last_fire = i;
      exp_trig = cond;
`endif
      if (i < n) begin
        v = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        d = (mode == 0) ? 1 : (int'($urandom_range(0, 2000)) - 1000);
      end else begin
        v = 1'b0;
        d = 0;
      end
      din = 32'(d);
      din_valid = v;
      if (v) begin
        q.push_back(d);
        if (q.size() > 16) void'(q.pop_front());
        s = 0;
        foreach (q[j]) s += q[j];
        exp_v[i + 5] = 1'b1;
        exp_d[i + 5] = 32'(s);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_restart();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      din = $urandom;
      din_valid = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (settled !== 1'b1) begin
      errors++;
      $display("FAIL restart_pre_settled: got %b required 1", settled);
    end
    din_valid = 1'b0;
    restart = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      restart = 1'b0;
      checks++;
      if (dout_valid !== 1'b0 || settled !== 1'b0 || {ma_rst, ma_din_valid, busy} !== exp_phase(k)) begin
        errors++;
        $display("FAIL restart_seq cycle %0d: got ov=%b settled=%b rst/dv/busy=%b required 0 0 %b",
                 k, dout_valid, settled, {ma_rst, ma_din_valid, busy}, exp_phase(k));
      end
    end
  endtask

`ifdef MA_CTRL_TRIG_EN
  task automatic test_trig();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (21) @(negedge clk);
    test_stream(0, 200);
  endtask
`endif

  task automatic test_ce();
    int p;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (ma_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_en_drop: got ma_rst=%b busy=%b required 1 0", ma_rst, busy);
    end
    for (int k = 0; k <= 31; k++) begin
      @(negedge clk);
      p = (k <= 5) ? k : (k <= 12) ? 5 : k - 7;
      checks++;
      if ({ma_rst, ma_din_valid, busy} !== exp_phase(p) || drop_cnt !== 16'(exp_drop)) begin
        errors++;
        $display("FAIL ce_freeze cycle %0d: got rst/dv/busy=%b drop=%0d required %b %0d",
                 k, {ma_rst, ma_din_valid, busy}, drop_cnt, exp_phase(p), exp_drop);
      end
      en = 1'b1;
      ce = !(k >= 5 && k <= 11);
      din_valid = !ce;
    end
    ce = 1'b1;
    din_valid = 1'b0;
  endtask

  task automatic test_en_drop();
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({ma_rst, ma_din_valid, busy} !== exp_phase((k <= 3) ? k : 0)) begin
        errors++;
        $display("FAIL en_drop cycle %0d: got rst/dv/busy=%b required %b",
                 k, {ma_rst, ma_din_valid, busy}, exp_phase((k <= 3) ? k : 0));
      end
      if (k == 0) en = 1'b1;
      if (k == 3) begin
        en = 1'b0;
        restart = 1'b1;
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_saturate();
    int cap;
    while (exp_drop < 65534) begin
      @(negedge clk);
      din_valid = 1'b1;
      exp_drop++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cap = (exp_drop > 65535) ? 65535 : exp_drop;
      checks++;
      if (drop_cnt !== 16'(cap)) begin
        errors++;
        $display("FAIL drop_saturate step %0d: got %0d required %0d", k, drop_cnt, cap);
      end
      exp_drop++;
    end
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scrub();
    test_stream(0, 40);
    test_restart();
    test_stream(1, 60);
`ifdef MA_CTRL_TRIG_EN
    test_trig();
`endif
    test_ce();
    test_en_drop();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
